data_fifo: RTL and testbench

//  Parametrised synchronous FIFO; successor to the fixed 4-bit DinA->DoutB register stage.

---
 rtl/data_fifo_pkg.sv | 29 ++
 rtl/fifo_ptr.sv | 33 +++
 rtl/data_fifo.sv | 107 ++++++++++
 tb/tb_data_fifo.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/data_fifo_pkg.sv
// data_fifo_pkg: shared width helpers for the data_fifo slice.
`default_nettype none

package data_fifo_pkg;

  // Ceiling log2 usable in parameter and port-width expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  function automatic int addr_w(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_ptr.sv
// fifo_ptr: storage-index pointer that wraps DEPTH-1 -> 0 by compare, so DEPTH need not be 2^n.
`default_nettype none

module fifo_ptr
  import data_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);

  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] r_ptr;

  always_ff @(posedge clock) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (inc) begin
      if (r_ptr == c_LAST) r_ptr <= '0;
      else                 r_ptr <= r_ptr + 1'b1;
    end
  end

  assign ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/data_fifo.sv
// data_fifo: single-clock FIFO with registered read data, occupancy count and sticky error flags.
`default_nettype none

module data_fifo
  import data_fifo_pkg::*;
#(
  parameter int W      = 4,
  parameter int DEPTH  = 8,
  parameter int AF_LVL = 6,
  localparam int ADDR_W = addr_w(DEPTH),
  localparam int CNT_W  = cnt_w(DEPTH)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [W-1:0]     DinA,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             clr_err,
  output logic [W-1:0]     DoutB,
  output logic             dout_valid,
  output logic             full,
  output logic             almost_full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_AF    = CNT_W'(AF_LVL);

  logic [W-1:0]      r_mem [DEPTH];
  logic [W-1:0]      r_dout;
  logic              r_dout_valid;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic              r_underflow;
  logic [ADDR_W-1:0] w_wr_ptr;
  logic [ADDR_W-1:0] w_rd_ptr;
  logic              w_full;
  logic              w_empty;
  logic              w_wr_acc;
  logic              w_rd_acc;

  assign w_full  = (r_count == c_DEPTH);
  assign w_empty = (r_count == '0);

  // A write into a full FIFO is allowed only when a read frees a slot in the same cycle.
  assign w_wr_acc = wr_en && (!w_full || rd_en) && !rst;
  assign w_rd_acc = rd_en && !w_empty && !rst;

  fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clock (clock),
    .rst   (rst),
    .inc   (w_wr_acc),
    .ptr   (w_wr_ptr)
  );

  fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clock (clock),
    .rst   (rst),
    .inc   (w_rd_acc),
    .ptr   (w_rd_ptr)
  );

  // Storage is not reset; the non-blocking read sees the old word when pointers coincide.
  always_ff @(posedge clock) begin
    if (w_wr_acc) r_mem[w_wr_ptr] <= DinA;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_dout_valid <= w_rd_acc;
      if (w_rd_acc) r_dout <= r_mem[w_rd_ptr];

      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (wr_en && w_full && !rd_en) r_overflow <= 1'b1;
      else if (clr_err)              r_overflow <= 1'b0;

      if (rd_en && w_empty) r_underflow <= 1'b1;
      else if (clr_err)     r_underflow <= 1'b0;
    end
  end

  assign DoutB       = r_dout;
  assign dout_valid  = r_dout_valid;
  assign count       = r_count;
  assign full        = w_full;
  assign empty       = w_empty;
  assign almost_full = (r_count >= c_AF);
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_data_fifo.sv
// tb_data_fifo: table-driven check of a DEPTH=4 FIFO plus a DEPTH=5 wrap/reset sequence.
`default_nettype none

module tb_data_fifo;

  logic       clock;
  logic       rst, wr_en, rd_en, clr_err;
  logic [3:0] DinA, DoutB;
  logic       dout_valid, full, almost_full, empty, overflow, underflow;
  logic [2:0] count;

  logic       b_rst, b_wr_en, b_rd_en, b_clr_err;
  logic [3:0] b_DinA, b_DoutB;
  logic       b_dout_valid, b_full, b_almost_full, b_empty, b_overflow, b_underflow;
  logic [2:0] b_count;

  data_fifo #(.W(4), .DEPTH(4), .AF_LVL(3)) dut_a (
    .clock(clock), .rst(rst), .DinA(DinA), .wr_en(wr_en), .rd_en(rd_en), .clr_err(clr_err),
    .DoutB(DoutB), .dout_valid(dout_valid), .full(full), .almost_full(almost_full),
    .empty(empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  data_fifo #(.W(4), .DEPTH(5), .AF_LVL(3)) dut_b (
    .clock(clock), .rst(b_rst), .DinA(b_DinA), .wr_en(b_wr_en), .rd_en(b_rd_en),
    .clr_err(b_clr_err), .DoutB(b_DoutB), .dout_valid(b_dout_valid), .full(b_full),
    .almost_full(b_almost_full), .empty(b_empty), .count(b_count), .overflow(b_overflow),
    .underflow(b_underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       wr, rd, clr;
    logic [3:0] din;
    int         cnt;
    logic       dv, ovf, udf;
  } vec_t;

  vec_t       vt[$];
  logic [3:0] mq[$], sb[$], mqb[$], sbb[$];
  logic [3:0] exp_dout, exp_b;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input logic wr, input logic rd, input logic clr,
                              input logic [3:0] din, input int cnt,
                              input logic dv, input logic ovf, input logic udf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.clr = clr; v.din = din;
    v.cnt = cnt; v.dv = dv; v.ovf = ovf; v.udf = udf;
    vt.push_back(v);
  endfunction

  task automatic apply_a(input vec_t v, input int idx);
    logic rd_ok, wr_ok;
    @(negedge clock);
    wr_en = v.wr; rd_en = v.rd; clr_err = v.clr; DinA = v.din;
    rd_ok = v.rd && (mq.size() != 0);
    wr_ok = v.wr && ((mq.size() != 4) || v.rd);
    if (rd_ok) sb.push_back(mq.pop_front());
    if (wr_ok) mq.push_back(v.din);
    @(posedge clock);
    #1;
    if (v.dv && sb.size() != 0) exp_dout = sb.pop_front();
    chk($sformatf("v%0d count", idx), int'(count), v.cnt);
    chk($sformatf("v%0d full", idx), int'(full), int'(v.cnt == 4));
    chk($sformatf("v%0d empty", idx), int'(empty), int'(v.cnt == 0));
    chk($sformatf("v%0d almost_full", idx), int'(almost_full), int'(v.cnt >= 3));
    chk($sformatf("v%0d dout_valid", idx), int'(dout_valid), int'(v.dv));
    chk($sformatf("v%0d overflow", idx), int'(overflow), int'(v.ovf));
    chk($sformatf("v%0d underflow", idx), int'(underflow), int'(v.udf));
    chk($sformatf("v%0d DoutB", idx), int'(DoutB), int'(exp_dout));
  endtask

  task automatic step_b(input logic wr, input logic rd, input logic [3:0] din, output logic wr_ok);
    logic rd_ok;
    @(negedge clock);
    b_wr_en = wr; b_rd_en = rd; b_DinA = din;
    rd_ok = rd && (mqb.size() != 0);
    wr_ok = wr && ((mqb.size() != 5) || rd);
    if (rd_ok) sbb.push_back(mqb.pop_front());
    if (wr_ok) mqb.push_back(din);
    @(posedge clock);
    #1;
    if (rd_ok) exp_b = sbb.pop_front();
    chk("B count", int'(b_count), mqb.size());
    chk("B dout_valid", int'(b_dout_valid), int'(rd_ok));
    chk("B DoutB", int'(b_DoutB), int'(exp_b));
  endtask

  initial begin
    logic       ok;
    logic [3:0] bd;

    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b0; clr_err = 1'b0; DinA = 4'hF;
    b_rst = 1'b1; b_wr_en = 1'b0; b_rd_en = 1'b0; b_clr_err = 1'b0; b_DinA = 4'h0;
    exp_dout = 4'h0; exp_b = 4'h0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset count", int'(count), 0);
    chk("reset empty", int'(empty), 1);
    chk("reset full", int'(full), 0);
    chk("reset almost_full", int'(almost_full), 0);
    chk("reset DoutB", int'(DoutB), 0);
    chk("reset dout_valid", int'(dout_valid), 0);
    chk("reset overflow", int'(overflow), 0);
    chk("reset underflow", int'(underflow), 0);
    @(negedge clock);
    rst = 1'b0; wr_en = 1'b0; b_rst = 1'b0;

    // Fill/drain with almost_full and full boundaries.
    for (int i = 1; i <= 4; i++) add(1, 0, 0, 4'(i), i, 0, 0, 0);
    for (int i = 3; i >= 0; i--) add(0, 1, 0, 4'h0, i, 1, 0, 0);
    // Overflow: the fifth word must never appear.
    for (int i = 1; i <= 4; i++) add(1, 0, 0, 4'(i), i, 0, 0, 0);
    add(1, 0, 0, 4'h5, 4, 0, 1, 0);
    for (int i = 3; i >= 0; i--) add(0, 1, 0, 4'h0, i, 1, 1, 0);
    add(0, 0, 1, 4'h0, 0, 0, 0, 0);
    // Simultaneous write+read while full, then drain across the wrap.
    for (int i = 1; i <= 4; i++) add(1, 0, 0, 4'(i), i, 0, 0, 0);
    add(1, 1, 0, 4'h9, 4, 1, 0, 0);
    for (int i = 3; i >= 0; i--) add(0, 1, 0, 4'h0, i, 1, 0, 0);
    // No fall-through on empty; set beats clear; then clear.
    add(1, 1, 0, 4'h7, 1, 0, 0, 1);
    add(0, 1, 0, 4'h0, 0, 1, 0, 1);
    add(0, 1, 1, 4'h0, 0, 0, 0, 1);
    add(0, 0, 1, 4'h0, 0, 0, 0, 0);

    for (int i = 0; i < vt.size(); i++) apply_a(vt[i], i);
    @(negedge clock);
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;

    // DEPTH=5 interleaved traffic with wrapping pointers.
    bd = 4'h0;
    for (int i = 0; i < 30; i++) begin
      step_b((i % 3) != 2, (i % 4) != 0, bd, ok);
      if (ok) bd = bd + 4'h1;
    end
    for (int i = 0; i < 6; i++) step_b(1'b0, 1'b1, 4'h0, ok);
    for (int i = 0; i < 3; i++) begin
      step_b(1'b1, 1'b0, bd, ok);
      bd = bd + 4'h1;
    end
    chk("B count before reset", int'(b_count), 3);

    // Reset mid-operation discards stored words.
    @(negedge clock);
    b_wr_en = 1'b0; b_rd_en = 1'b0; b_rst = 1'b1;
    mqb.delete(); sbb.delete(); exp_b = 4'h0;
    @(posedge clock);
    #1;
    chk("B reset count", int'(b_count), 0);
    chk("B reset empty", int'(b_empty), 1);
    chk("B reset DoutB", int'(b_DoutB), 0);
    @(negedge clock);
    b_rst = 1'b0;
    step_b(1'b0, 1'b1, 4'h0, ok);
    chk("B underflow after reset", int'(b_underflow), 1);
    step_b(1'b1, 1'b0, 4'hA, ok);
    step_b(1'b0, 1'b1, 4'h0, ok);
    step_b(1'b0, 1'b0, 4'h0, ok);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
